// File: rtl/dual_req_arbiter.sv
// Two-requester round-robin arbiter with bounded grant hold time.
// One requester owns the shared resource at a time; a grant ends on the
// owner's done pulse, when its request drops, or when it has held the
// resource for HOLD_MAX cycles while the other side is waiting. Every
// release is followed by TURN_CYC idle turnaround cycles. Grants and the
// state code are registered, so they change only on the clock edge.
module dual_req_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       p1,
    input  logic       p2,
    input  logic       done1,
    input  logic       done2,
    output logic       g1,
    output logic       g2,
    output logic [2:0] Y
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        GNT1 = 3'b001,
        GNT2 = 3'b010,
        TURN = 3'b100
    } state_t;

    localparam logic [3:0] HoldLim = 4'(HOLD_MAX);
    localparam logic [2:0] TurnLim = 3'(TURN_CYC);

    state_t     state_q, state_d;
    logic [3:0] holdCnt_q, holdCnt_d;
    logic [2:0] turnCnt_q, turnCnt_d;
    // Set when requester 2 was the last one served; p1 then wins a tie.
    logic       lastP2_q, lastP2_d;
    logic       g1_q, g2_q;
    logic [2:0] y_q;

    // done2 only matters while requester 2 holds the grant and done1 only
    // while requester 1 does; the other pulse is deliberately ignored.

    // Next-state logic: arbitration, hold-time limit and turnaround counting.
    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        turnCnt_d = turnCnt_q;
        lastP2_d  = lastP2_q;
        unique case (state_q)
            IDLE: begin
                if (p1 && (!p2 || lastP2_q)) begin
                    state_d   = GNT1;
                    holdCnt_d = 4'd1;
                end else if (p2) begin
                    state_d   = GNT2;
                    holdCnt_d = 4'd1;
                end
            end
            GNT1: begin
                if (done1 || !p1 || (holdCnt_q == HoldLim && p2)) begin
                    state_d   = TURN;
                    holdCnt_d = 4'd0;
                    turnCnt_d = 3'd1;
                    lastP2_d  = 1'b0;
                end else if (holdCnt_q < HoldLim) begin
                    holdCnt_d = holdCnt_q + 4'd1;
                end
            end
            GNT2: begin
                if (done2 || !p2 || (holdCnt_q == HoldLim && p1)) begin
                    state_d   = TURN;
                    holdCnt_d = 4'd0;
                    turnCnt_d = 3'd1;
                    lastP2_d  = 1'b1;
                end else if (holdCnt_q < HoldLim) begin
                    holdCnt_d = holdCnt_q + 4'd1;
                end
            end
            TURN: begin
                if (turnCnt_q >= TurnLim) begin
                    turnCnt_d = 3'd0;
                    if (p1 && (!p2 || lastP2_q)) begin
                        state_d   = GNT1;
                        holdCnt_d = 4'd1;
                    end else if (p2) begin
                        state_d   = GNT2;
                        holdCnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turnCnt_d = turnCnt_q + 3'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                holdCnt_d = 4'd0;
                turnCnt_d = 3'd0;
            end
        endcase
    end

    // State register with synchronous reset; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_q   <= IDLE;
            holdCnt_q <= 4'd0;
            turnCnt_q <= 3'd0;
            lastP2_q  <= 1'b1;
            g1_q      <= 1'b0;
            g2_q      <= 1'b0;
            y_q       <= 3'b000;
        end else begin
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            turnCnt_q <= turnCnt_d;
            lastP2_q  <= lastP2_d;
            g1_q      <= (state_d == GNT1);
            g2_q      <= (state_d == GNT2);
            y_q       <= state_d;
        end
    end

    assign g1 = g1_q;
    assign g2 = g2_q;
    assign Y  = y_q;

endmodule

// File: tb/tb_dual_req_arbiter.sv
// Directed bench for dual_req_arbiter with default parameters
// (HOLD_MAX=4, TURN_CYC=1). Each vector is driven on the falling edge,
// clocked in on the rising edge, and the outputs are checked 1 ns later
// against the state the arbiter must be in after that edge.
module tb_dual_req_arbiter;

    typedef struct {
        string      name;
        logic       rs;
        logic       p1;
        logic       p2;
        logic       d1;
        logic       d2;
        logic       expG1;
        logic       expG2;
        logic [2:0] expY;
    } vec_t;

    logic       clk;
    logic       rs;
    logic       p1;
    logic       p2;
    logic       done1;
    logic       done2;
    logic       g1;
    logic       g2;
    logic [2:0] Y;

    int   numChecks;
    int   numFails;
    vec_t vecs[$];

    dual_req_arbiter #(.HOLD_MAX(4), .TURN_CYC(1)) dut (
        .clk   (clk),
        .rs    (rs),
        .p1    (p1),
        .p2    (p2),
        .done1 (done1),
        .done2 (done2),
        .g1    (g1),
        .g2    (g2),
        .Y     (Y)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected grants follow directly from the state code.
    task automatic addVec(input string name, input logic vrs, input logic vp1,
                          input logic vp2, input logic vd1, input logic vd2,
                          input logic [2:0] y);
        vec_t v;
        v.name  = name;
        v.rs    = vrs;
        v.p1    = vp1;
        v.p2    = vp2;
        v.d1    = vd1;
        v.d2    = vd2;
        v.expY  = y;
        v.expG1 = (y == 3'b001);
        v.expG2 = (y == 3'b010);
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input vec_t v);
        numChecks++;
        if (g1 !== v.expG1) begin
            numFails++;
            $display("[TB] FAIL %s g1: got %b want %b", v.name, g1, v.expG1);
        end
        numChecks++;
        if (g2 !== v.expG2) begin
            numFails++;
            $display("[TB] FAIL %s g2: got %b want %b", v.name, g2, v.expG2);
        end
        numChecks++;
        if (Y !== v.expY) begin
            numFails++;
            $display("[TB] FAIL %s Y: got %b want %b", v.name, Y, v.expY);
        end
        numChecks++;
        if ((g1 & g2) !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL %s exclusive: got g1&g2=%b want 0", v.name, g1 & g2);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rs    = v.rs;
        p1    = v.p1;
        p2    = v.p2;
        done1 = v.d1;
        done2 = v.d2;
        @(posedge clk);
        #1;
        checkOutput(v);
    endtask

    task automatic runOne(input string name, input logic vrs, input logic vp1,
                          input logic vp2, input logic vd1, input logic vd2,
                          input logic [2:0] y);
        vec_t v;
        v.name  = name;
        v.rs    = vrs;
        v.p1    = vp1;
        v.p2    = vp2;
        v.d1    = vd1;
        v.d2    = vd2;
        v.expY  = y;
        v.expG1 = (y == 3'b001);
        v.expG2 = (y == 3'b010);
        applyStimulus(v);
    endtask

    // Table of directed vectors followed by hand-written corner sequences.
    initial begin
        numChecks = 0;
        numFails  = 0;
        rs    = 1'b1;
        p1    = 1'b0;
        p2    = 1'b0;
        done1 = 1'b0;
        done2 = 1'b0;

        // Reset held with both requests pending, then first grant to p1.
        addVec("rst_pend0", 1, 1, 1, 0, 0, 3'b000);
        addVec("rst_pend1", 1, 1, 1, 0, 0, 3'b000);
        addVec("rst_first", 0, 1, 1, 0, 0, 3'b001);
        // Continuous contention: 4 x GNT1, TURN, 4 x GNT2, TURN, GNT1.
        for (int k = 0; k < 3; k++) addVec("cont_g1", 0, 1, 1, 0, 0, 3'b001);
        addVec("cont_t1", 0, 1, 1, 0, 0, 3'b100);
        for (int k = 0; k < 4; k++) addVec("cont_g2", 0, 1, 1, 0, 0, 3'b010);
        addVec("cont_t2", 0, 1, 1, 0, 0, 3'b100);
        addVec("cont_wrap", 0, 1, 1, 0, 0, 3'b001);
        // Early release: done1 in the 2nd GNT1 cycle.
        addVec("early_g1b", 0, 1, 1, 0, 0, 3'b001);
        addVec("early_done", 0, 1, 1, 1, 0, 3'b100);
        addVec("early_g2", 0, 1, 1, 0, 0, 3'b010);
        // p2 drops: GNT2 releases, then p1 alone gets the resource.
        addVec("drop_p2", 0, 1, 0, 0, 0, 3'b100);
        addVec("p1_alone", 0, 1, 0, 0, 0, 3'b001);
        // Foreign done2 ignored while GNT1 and p2 idle; hold saturates.
        addVec("foreign_d2a", 0, 1, 0, 0, 1, 3'b001);
        addVec("foreign_d2b", 0, 1, 0, 0, 1, 3'b001);
        for (int k = 0; k < 4; k++) addVec("p1_persist", 0, 1, 0, 0, 0, 3'b001);
        addVec("p1_drop", 0, 0, 0, 0, 0, 3'b100);
        addVec("p1_idle", 0, 0, 0, 0, 0, 3'b000);
        addVec("idle_stay", 0, 0, 0, 0, 0, 3'b000);
        // Single requester p2 for 10 cycles, then release.
        for (int k = 0; k < 10; k++) addVec("single_p2", 0, 0, 1, 0, 0, 3'b010);
        addVec("single_drop", 0, 0, 0, 0, 0, 3'b100);
        addVec("single_idle", 0, 0, 0, 0, 0, 3'b000);
        // Make p1 last-served, then reset in the 3rd GNT2 cycle.
        addVec("pre_g1", 0, 1, 0, 0, 0, 3'b001);
        addVec("pre_turn", 0, 0, 0, 0, 0, 3'b100);
        addVec("pre_idle", 0, 0, 0, 0, 0, 3'b000);
        addVec("mid_g2a", 0, 0, 1, 0, 0, 3'b010);
        addVec("mid_g2b", 0, 1, 1, 0, 0, 3'b010);
        addVec("mid_g2c", 0, 1, 1, 0, 0, 3'b010);
        addVec("mid_rst", 1, 1, 1, 0, 0, 3'b000);
        addVec("mid_after", 0, 1, 1, 0, 0, 3'b001);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // done1 coinciding with the hold timeout: one exit, one TURN, then a full GNT2.
        runOne("coin_g1b", 0, 1, 1, 0, 0, 3'b001);
        runOne("coin_g1c", 0, 1, 1, 0, 0, 3'b001);
        runOne("coin_g1d", 0, 1, 1, 0, 0, 3'b001);
        runOne("coin_exit", 0, 1, 1, 1, 0, 3'b100);
        for (int k = 0; k < 4; k++) runOne("coin_g2", 0, 1, 1, 0, 0, 3'b010);
        runOne("coin_t2", 0, 1, 1, 0, 0, 3'b100);

        // Request dropped during TURN is not granted: p2 waiting, p1 gone.
        runOne("tdrop_g1", 0, 1, 0, 0, 0, 3'b001);
        runOne("tdrop_rel", 0, 1, 1, 1, 0, 3'b100);
        runOne("tdrop_none", 0, 0, 0, 0, 0, 3'b000);

        // Reset while in TURN returns to IDLE with no grant on that edge.
        runOne("trst_g2", 0, 0, 1, 0, 0, 3'b010);
        runOne("trst_rel", 0, 0, 1, 0, 1, 3'b100);
        runOne("trst_rst", 1, 1, 1, 0, 0, 3'b000);
        runOne("trst_after", 0, 1, 1, 0, 0, 3'b001);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion want finish before 100000 ns");
        $fatal(1, "[TB] timeout");
    end

endmodule
